// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and helpers for the adder-sharing arbiter.
package adder_share_pkg;

    localparam int unsigned CORE_W = 6;

    typedef enum logic {EMPTY, FULL} slot_e;

    typedef logic [CORE_W-1:0] word_t;

    // Registered core result held in the response slot.
    typedef struct packed {
        logic  co;
        word_t sum;
    } sum_t;

    function automatic int unsigned idw(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Requester, adder-core and response signals of the adder-sharing arbiter.
interface adder_share_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    import adder_share_pkg::*;

    localparam int unsigned IDW = idw(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*CORE_W-1:0] req_x;
    logic [NREQ*CORE_W-1:0] req_y;
    word_t                  core_x;
    word_t                  core_y;
    word_t                  core_s;
    logic                   core_co;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    word_t                  rsp_sum;
    logic                   rsp_co;

    modport slave (
        input  req_valid, req_x, req_y, core_s, core_co, rsp_ready,
        output req_ready, core_x, core_y, rsp_valid, rsp_id, rsp_sum, rsp_co
    );

    modport master (
        output req_valid, req_x, req_y, core_s, core_co, rsp_ready,
        input  req_ready, core_x, core_y, rsp_valid, rsp_id, rsp_sum, rsp_co
    );

endinterface

// File: rtl/adder_share_arbiter_rr_pick.sv
// Round-robin picker: first set request scanning from ptr upward, wrapping mod N.
module rr_pick
    import adder_share_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = idw(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    int unsigned idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt_idx  = IW'(idx);
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Arbitrates NREQ requesters onto one external 6-bit adder core with a one-deep response slot.
// Build option ADDER_SHARE_PRIO0_EN: requester 0 gets fixed absolute priority.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    adder_share_arbiter_if.slave bus
);

    localparam int unsigned IDW = idw(NREQ);

    slot_e          state_q, state_d;
    sum_t           rsp_q, rsp_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0] pick_req;
    logic [NREQ-1:0] pick_gnt;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;

    logic [NREQ-1:0] win_gnt;
    logic [IDW-1:0]  win_idx;
    logic            win_any;
    logic            win_rr;
    logic            can_accept;
    logic            hs;

`ifdef ADDER_SHARE_PRIO0_EN
    assign pick_req = bus.req_valid & ~NREQ'(1);
`else
    assign pick_req = bus.req_valid;
`endif

    rr_pick #(.N(NREQ)) u_pick (
        .req     (pick_req),
        .ptr     (rr_ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Winner selection, handshake and operand mux toward the core.
    always_comb begin
        win_gnt = pick_gnt;
        win_idx = pick_idx;
        win_any = pick_any;
        win_rr  = pick_any;
`ifdef ADDER_SHARE_PRIO0_EN
        if (bus.req_valid[0]) begin
            win_gnt = NREQ'(1);
            win_idx = '0;
            win_any = 1'b1;
            win_rr  = 1'b0;
        end
`endif
        can_accept    = (state_q == EMPTY) || bus.rsp_ready;
        hs            = win_any && can_accept && rst_n;
        bus.req_ready = hs ? win_gnt : '0;
        bus.core_x    = '0;
        bus.core_y    = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (hs && (int'(win_idx) == i)) begin
                bus.core_x = bus.req_x[i*CORE_W +: CORE_W];
                bus.core_y = bus.req_y[i*CORE_W +: CORE_W];
            end
        end
    end

    // Slot FSM next state, response capture and pointer advance.
    always_comb begin
        state_d  = state_q;
        rsp_d    = rsp_q;
        rsp_id_d = rsp_id_q;
        rr_ptr_d = rr_ptr_q;
        if (hs) begin
            state_d  = FULL;
            rsp_d    = '{co: bus.core_co, sum: bus.core_s};
            rsp_id_d = win_idx;
            if (win_rr) begin
                rr_ptr_d = (32'(win_idx) == NREQ - 1) ? '0 : win_idx + IDW'(1);
            end
        end else if ((state_q == FULL) && bus.rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            rsp_q    <= '0;
            rsp_id_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rsp_q    <= rsp_d;
            rsp_id_q <= rsp_id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_q.sum;
    assign bus.rsp_co    = rsp_q.co;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter with a behavioural adder core and response scoreboard.
module tb_adder_share_arbiter;
    import adder_share_pkg::*;

    localparam int unsigned NREQ = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adder_share_arbiter_if #(.NREQ(NREQ)) bus ();

    adder_share_arbiter #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External adder core model: unsigned add, no carry-in.
    assign {bus.core_co, bus.core_s} = 7'(bus.core_x) + 7'(bus.core_y);

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] id;
        logic [5:0] sum;
        logic       co;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend_e;
    int   m_ptr    = 0;
    int   pend_g   = -1;
    bit   pend_pop = 1'b0;

    function automatic int model_pick(input logic [3:0] v, input int ptr);
`ifdef ADDER_SHARE_PRIO0_EN
        if (v[0]) return 0;
        v[0] = 1'b0;
`endif
        for (int k = 0; k < int'(NREQ); k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Scoreboard: check outputs mid-cycle, predict the handshake of the coming edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            logic       exp_rv;
            logic [3:0] exp_rdy;
            int         g;
            exp_rv = (exp_q.size() != 0);
            n_vec++;
            if (bus.rsp_valid !== exp_rv) begin
                n_err++;
                $display("FAIL sb_rsp_valid got=%b exp=%b t=%0t", bus.rsp_valid, exp_rv, $time);
            end else if (exp_rv) begin
                n_vec++;
                if (bus.rsp_id !== exp_q[0].id || bus.rsp_sum !== exp_q[0].sum || bus.rsp_co !== exp_q[0].co) begin
                    n_err++;
                    $display("FAIL sb_rsp got id=%0d sum=%0d co=%b exp id=%0d sum=%0d co=%b t=%0t",
                             bus.rsp_id, bus.rsp_sum, bus.rsp_co, exp_q[0].id, exp_q[0].sum, exp_q[0].co, $time);
                end
            end
            g = (!exp_rv || bus.rsp_ready === 1'b1) ? model_pick(bus.req_valid, m_ptr) : -1;
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
            n_vec++;
            if (bus.req_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL sb_req_ready got=%b exp=%b t=%0t", bus.req_ready, exp_rdy, $time);
            end
            pend_g   = g;
            pend_pop = exp_rv && (bus.rsp_ready === 1'b1);
            if (g >= 0) begin
                pend_e.id = 2'(g);
                {pend_e.co, pend_e.sum} = 7'(bus.req_x[g*6 +: 6]) + 7'(bus.req_y[g*6 +: 6]);
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (rst_n !== 1'b1) begin
            exp_q.delete();
            m_ptr    = 0;
            pend_g   = -1;
            pend_pop = 1'b0;
        end else begin
            if (pend_pop) void'(exp_q.pop_front());
            if (pend_g >= 0) begin
                exp_q.push_back(pend_e);
`ifdef ADDER_SHARE_PRIO0_EN
                if (pend_g != 0) m_ptr = (pend_g + 1) % NREQ;
`else
                m_ptr = (pend_g + 1) % NREQ;
`endif
            end
            pend_g   = -1;
            pend_pop = 1'b0;
        end
    end

    task automatic drive(input logic [3:0] v, input logic rdy);
        bus.req_valid = v;
        bus.rsp_ready = rdy;
    endtask

    task automatic set_op(input int i, input logic [5:0] x, input logic [5:0] y);
        bus.req_x[i*6 +: 6] = x;
        bus.req_y[i*6 +: 6] = y;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < int'(NREQ); i++) set_op(i, 6'($urandom), 6'($urandom));
    endtask

    // Leaves the bench just after a rising edge with the DUT out of reset.
    task automatic apply_reset();
        rst_n = 1'b0;
        drive(4'b0000, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_x = '0;
        bus.req_y = '0;
        drive(4'b1111, 1'b1);
        repeat (2) @(negedge clk);
        n_vec++;
        if (bus.req_ready !== 4'b0000) begin
            n_err++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready);
        end
        n_vec++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 || bus.rsp_sum !== 6'd0 || bus.rsp_co !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rsp got v=%b id=%0d sum=%0d co=%b exp all 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_co);
        end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        set_op(0, 6'd5, 6'd9);
        drive(4'b0001, 1'b1);
        @(negedge clk);
        n_vec++;
        if (bus.req_ready !== 4'b0001) begin
            n_err++; $display("FAIL single_grant got=%b exp=0001", bus.req_ready);
        end
        @(posedge clk); #1;
        drive(4'b0000, 1'b1);
        @(negedge clk);
        n_vec++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_sum !== 6'd14 || bus.rsp_co !== 1'b0) begin
            n_err++;
            $display("FAIL single_rsp got v=%b id=%0d sum=%0d co=%b exp v=1 id=0 sum=14 co=0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_co);
        end
    endtask

    task automatic test_carry();
        @(posedge clk); #1;
        set_op(0, 6'd63, 6'd1);
        drive(4'b0001, 1'b1);
        @(posedge clk); #1;
        set_op(0, 6'd63, 6'd63);
        @(negedge clk);
        n_vec++;
        if (bus.rsp_sum !== 6'd0 || bus.rsp_co !== 1'b1) begin
            n_err++; $display("FAIL carry_63p1 got sum=%0d co=%b exp sum=0 co=1", bus.rsp_sum, bus.rsp_co);
        end
        @(posedge clk); #1;
        drive(4'b0000, 1'b1);
        @(negedge clk);
        n_vec++;
        if (bus.rsp_sum !== 6'd62 || bus.rsp_co !== 1'b1) begin
            n_err++; $display("FAIL carry_63p63 got sum=%0d co=%b exp sum=62 co=1", bus.rsp_sum, bus.rsp_co);
        end
    endtask

`ifndef ADDER_SHARE_PRIO0_EN
    task automatic test_fairness();
        apply_reset();
        rand_ops();
        drive(4'b1111, 1'b1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_vec++;
            if (bus.req_ready !== 4'(1 << (c % 4))) begin
                n_err++; $display("FAIL fair_grant c=%0d got=%b exp=%b", c, bus.req_ready, 4'(1 << (c % 4)));
            end
            if (c > 0) begin
                n_vec++;
                if (bus.rsp_id !== 2'((c - 1) % 4)) begin
                    n_err++; $display("FAIL fair_rsp_id c=%0d got=%0d exp=%0d", c, bus.rsp_id, (c - 1) % 4);
                end
            end
            @(posedge clk); #1;
            rand_ops();
        end
        drive(4'b0000, 1'b1);
    endtask
`endif

    task automatic test_backpressure();
        @(posedge clk); #1;
        drive(4'b0000, 1'b1);
        @(posedge clk); #1;
        rand_ops();
        drive(4'b1111, 1'b0);
        @(negedge clk);
        n_vec++;
        if ($countones(bus.req_ready) != 1) begin
            n_err++; $display("FAIL bp_first_grant got=%b exp one-hot", bus.req_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            rand_ops();
            @(negedge clk);
            n_vec++;
            if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b1) begin
                n_err++; $display("FAIL bp_stall c=%0d got rdy=%b v=%b exp rdy=0000 v=1", c, bus.req_ready, bus.rsp_valid);
            end
            n_vec++;
            if (bus.core_x !== 6'd0 || bus.core_y !== 6'd0) begin
                n_err++; $display("FAIL bp_core_quiet got x=%0d y=%0d exp 0 0", bus.core_x, bus.core_y);
            end
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if ($countones(bus.req_ready) != 1) begin
            n_err++; $display("FAIL bp_refill got=%b exp one-hot", bus.req_ready);
        end
        @(posedge clk); #1;
        drive(4'b0000, 1'b1);
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_op(2, 6'd20, 6'd30);
        drive(4'b0100, 1'b0);
        @(posedge clk); #1;
        drive(4'b0000, 1'b0);
        @(negedge clk);
        n_vec++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2) begin
            n_err++; $display("FAIL ar_full got v=%b id=%0d exp v=1 id=2", bus.rsp_valid, bus.rsp_id);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
            n_err++; $display("FAIL ar_drop got v=%b rdy=%b exp v=0 rdy=0000", bus.rsp_valid, bus.req_ready);
        end
        #3;
        rand_ops();
        drive(4'b1111, 1'b1);
        #3 rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.req_ready !== 4'b0001) begin
            n_err++; $display("FAIL ar_first_grant got=%b exp=0001", bus.req_ready);
        end
        @(posedge clk); #1;
        drive(4'b0000, 1'b1);
    endtask

`ifdef ADDER_SHARE_PRIO0_EN
    task automatic test_prio0();
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0010;
        apply_reset();
        rand_ops();
        drive(4'b1111, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_vec++;
            if (bus.req_ready !== 4'b0001) begin
                n_err++; $display("FAIL prio0_hold c=%0d got=%b exp=0001", c, bus.req_ready);
            end
            @(posedge clk); #1;
        end
        bus.req_valid = 4'b1110;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_vec++;
            if (bus.req_ready !== exp_seq[c]) begin
                n_err++; $display("FAIL prio0_rr c=%0d got=%b exp=%b", c, bus.req_ready, exp_seq[c]);
            end
            @(posedge clk); #1;
        end
        drive(4'b0000, 1'b1);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_carry();
`ifndef ADDER_SHARE_PRIO0_EN
        test_fairness();
`endif
        test_backpressure();
        test_async_reset();
`ifdef ADDER_SHARE_PRIO0_EN
        test_prio0();
`endif
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
